dds_serial_writer: RTL and testbench
====================================

# dds_serial_writer

Serial programming engine for the DDS chip. Runs on the 50 MHz reference clock and consumes the 10 MHz divider output (`TenMHz_receiver`) as a bit-rate enable, not as a clock. It accepts an instruction byte plus 0–8 data bytes from the control logic and shifts them MSB-first onto the DDS serial port (CS, SCLK, SDIO). It then pulses IO_UPDATE so the DDS applies the new register contents.

## Interface
- `MAX_BYTES`, 8: maximum data bytes per transfer; sets the width of `data` (8*MAX_BYTES).
- `IO_UPDATE_CYCLES`, 4: IO_UPDATE pulse width in reference clocks, range 1–15.
- `FiftyMHz_ref_clock`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `TenMHz_receiver`  in  1  10 MHz divider output, synchronous to the ref clock; each rising edge is one tick.
- `start`  in  1  request a transfer; sampled only while `busy`=0.
- `instr`  in  8  DDS instruction byte (R/W + address).
- `data`  in  8*MAX_BYTES  payload; byte k occupies bits [8k+7:8k].
- `num_bytes`  in  4  number of data bytes, 0..MAX_BYTES; values >MAX_BYTES are clamped.
- `busy`  out  1  high from the cycle after acceptance until `done`.
- `done`  out  1  one-cycle pulse when the transfer completes.
- `dds_cs_n`  out  1  DDS chip select, active low.
- `dds_sclk`  out  1  serial clock; the DDS samples on the rising edge.
- `dds_sdio`  out  1  serial data.
- `dds_io_update`  out  1  register-apply strobe.

## Operation
- Tick detection: `tick` = `TenMHz_receiver` & ~prev, where prev is registered. prev resets to 1, so no tick is generated out of reset unless a real rising edge occurs.
- Acceptance: `start`=1 and `busy`=0 latch `instr`, `data`, and clamped `num_bytes`. The inputs may then change freely. N = 8*(1+num_bytes) bits.
- Bit order: `instr[7]` down to `instr[0]`, then data byte num_bytes-1 down to byte 0, each byte MSB first.
- FSM states: IDLE, CS_SETUP, SHIFT, CS_HOLD, UPDATE.
  - IDLE → CS_SETUP on acceptance. `dds_cs_n` goes low and `busy` goes high in the next cycle.
  - CS_SETUP, on tick: drive `dds_sclk`=0 and `dds_sdio`=first bit, then go to SHIFT.
  - SHIFT, on each tick: toggle `dds_sclk`.
    - On a 1→0 toggle, present the next bit.
    - After the Nth rising edge, the next tick drives sclk=0 and moves to CS_HOLD.
  - CS_HOLD, on tick: `dds_cs_n`=1, then go to UPDATE.
  - UPDATE: hold `dds_io_update`=1 for IO_UPDATE_CYCLES ref clocks. In the following cycle: io_update=0, `done`=1, `busy`=0, return to IDLE.
- Bit counter is 7 bits wide (N ≤ 72). It counts rising SCLK edges and never wraps within a transfer.
- `start` while `busy`=1 is ignored; it is not queued.
- `start` in the `done` cycle is accepted, giving back-to-back transfers.
- Reset mid-transfer aborts immediately: CS deasserts and no IO_UPDATE is issued.

## Timing
- Reset values: `busy`=0, `done`=0, `dds_cs_n`=1, `dds_sclk`=0, `dds_sdio`=0, `dds_io_update`=0, state=IDLE.
- Tick latency: one ref clock after the `TenMHz_receiver` rising edge.
- With the 5-clock divider: SCLK period = 10 ref clocks (5 MHz). SDIO setup before and hold after each SCLK rise = 5 ref clocks.
- Transfer span, from the first tick after acceptance to CS rising: 2N+1 ticks. `done` follows IO_UPDATE_CYCLES+1 clocks after CS rises.
- CS-to-first-SCLK-rise ≥ 1 tick; last SCLK fall to CS rise = 1 tick.
- The block depends only on tick edges, not on the tick period. An idle `TenMHz_receiver` stalls the transfer indefinitely with all outputs held.

## Structure
- Shared package/include `dds_serial_pkg`:
  - state encoding constants (IDLE..UPDATE)
  - `DDS_INSTR_BITS`=8
  - `DDS_MAX_BITS`=8*(1+MAX_BYTES)
- One sub-module, `tick_edge_detect`: prev register plus rising-edge strobe, reset value 1. It is reusable for other consumers of the divider output.
- The shift register is loaded as {instr, data bytes} left-justified and shifted left on each SCLK fall.

## Test plan
- Reset, then drive the 10 MHz divider for 20 ticks with no start → all outputs at reset values, no SCLK activity.
- instr=0x8A, num_bytes=0 → exactly 8 SCLK rises. SDIO sampled at the rises = 1,0,0,0,1,0,1,0. CS low throughout. IO_UPDATE high for 4 clocks, then `done` pulses once.
- instr=0x01, num_bytes=4, data[31:0]=0xDEADBEEF → 40 rises; bitstream 0x01DEADBEEF MSB first. CS low span = 81 ticks.
- num_bytes=12 → clamped to 8: 72 rises. A second `start` issued mid-transfer is ignored (one `done` only).
- Assert `start` in the `done` cycle with instr=0x02 → second transfer accepted. CS rises for at least 1 tick between the two transfers.
- Assert `reset` at SCLK rise 13 of a 40-bit transfer → same-cycle CS=1, SCLK=0, IO_UPDATE never pulses, `busy`=0. A subsequent transfer completes normally.

Source files
------------

// File: rtl/dds_serial_pkg.sv
// dds_serial_pkg
// Shared definitions for the DDS serial programming engine: FSM state
// encoding, instruction width and the worst-case serial frame length.
// No ports; imported by dds_serial_writer.
package dds_serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_CS_HOLD  = 3'd3,
    ST_UPDATE   = 3'd4
  } dds_state_t;

  localparam int DDS_INSTR_BITS = 8;
  localparam int DDS_MAX_BYTES  = 8;
  localparam int DDS_MAX_BITS   = 8 * (1 + DDS_MAX_BYTES);

endpackage

// File: rtl/dds_serial_writer_tick_edge_detect.sv
// tick_edge_detect
// Turns a slow divider output that is synchronous to clk into a one-clock
// strobe on each of its rising edges. The history register resets to 1 so
// that a divider sitting high out of reset does not produce a spurious tick.
// Ports:
//   clk   in  reference clock
//   rst   in  asynchronous active-high reset
//   level in  divider output
//   tick  out one-cycle strobe, high in the cycle after level rises
module tick_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic tick
);

  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b1;
    else     prev <= level;
  end

  assign tick = level & ~prev;

endmodule

// File: rtl/dds_serial_writer.sv
// dds_serial_writer
// Serial programming engine for the DDS chip. Accepts an instruction byte
// plus 0..MAX_BYTES data bytes, shifts them MSB first on CS/SCLK/SDIO using
// the 10 MHz divider output as a bit-rate enable, then strobes IO_UPDATE.
// Ports:
//   FiftyMHz_ref_clock in  sole clock (rising edge)
//   reset              in  asynchronous active-high reset
//   TenMHz_receiver    in  divider output; each rising edge is one tick
//   start              in  transfer request, sampled while idle
//   instr              in  instruction byte
//   data               in  payload, byte k at [8k+7:8k]
//   num_bytes          in  payload byte count, clamped to MAX_BYTES
//   busy               out transfer in progress
//   done               out one-cycle completion pulse
//   dds_cs_n           out chip select, active low
//   dds_sclk           out serial clock, DDS samples on rising edge
//   dds_sdio           out serial data
//   dds_io_update      out register-apply strobe
module dds_serial_writer
  import dds_serial_pkg::*;
#(
  parameter int MAX_BYTES        = 8,
  parameter int IO_UPDATE_CYCLES = 4
) (
  input  logic                   FiftyMHz_ref_clock,
  input  logic                   reset,
  input  logic                   TenMHz_receiver,
  input  logic                   start,
  input  logic [7:0]             instr,
  input  logic [8*MAX_BYTES-1:0] data,
  input  logic [3:0]             num_bytes,
  output logic                   busy,
  output logic                   done,
  output logic                   dds_cs_n,
  output logic                   dds_sclk,
  output logic                   dds_sdio,
  output logic                   dds_io_update
);

  localparam int         SHIFT_W = DDS_INSTR_BITS + 8 * MAX_BYTES;
  localparam logic [3:0] MAX_NB  = 4'(MAX_BYTES);
  localparam logic [3:0] UPD_LEN = 4'(IO_UPDATE_CYCLES);

  function automatic logic [3:0] sat_num_bytes(input logic [3:0] nb);
    return (nb > MAX_NB) ? MAX_NB : nb;
  endfunction

  dds_state_t          state_r, state_nxt;
  logic                busy_r, busy_nxt;
  logic                done_r, done_nxt;
  logic                cs_n_r, cs_n_nxt;
  logic                sclk_r, sclk_nxt;
  logic                sdio_r, sdio_nxt;
  logic                io_upd_r, io_upd_nxt;
  logic [6:0]          bit_cnt_r, bit_cnt_nxt;
  logic [3:0]          upd_cnt_r, upd_cnt_nxt;
  logic [6:0]          nbits_r, nbits_nxt;
  logic [SHIFT_W-1:0]  shreg_r, shreg_nxt;

  logic                tick;
  logic [3:0]          nb_sat;
  logic [6:0]          pad_bits;
  logic [6:0]          load_bits;
  logic [SHIFT_W-1:0]  load_word;

  tick_edge_detect u_tick (
    .clk   (FiftyMHz_ref_clock),
    .rst   (reset),
    .level (TenMHz_receiver),
    .tick  (tick)
  );

  // Frame load: the used payload bytes are pushed up against the
  // instruction so the whole frame is left-justified in the shift register.
  always_comb begin
    nb_sat    = sat_num_bytes(num_bytes);
    pad_bits  = {MAX_NB - nb_sat, 3'b000};
    load_word = {instr, data << pad_bits};
    load_bits = {nb_sat, 3'b000} + 7'd8;
  end

  always_comb begin
    state_nxt   = state_r;
    busy_nxt    = busy_r;
    done_nxt    = 1'b0;
    cs_n_nxt    = cs_n_r;
    sclk_nxt    = sclk_r;
    sdio_nxt    = sdio_r;
    io_upd_nxt  = io_upd_r;
    bit_cnt_nxt = bit_cnt_r;
    upd_cnt_nxt = upd_cnt_r;
    nbits_nxt   = nbits_r;
    shreg_nxt   = shreg_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          shreg_nxt   = load_word;
          nbits_nxt   = load_bits;
          bit_cnt_nxt = '0;
          upd_cnt_nxt = '0;
          cs_n_nxt    = 1'b0;
          busy_nxt    = 1'b1;
          state_nxt   = ST_CS_SETUP;
        end
      end
      ST_CS_SETUP: begin
        if (tick) begin
          sclk_nxt  = 1'b0;
          sdio_nxt  = shreg_r[SHIFT_W-1];
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (!sclk_r) begin
            sclk_nxt    = 1'b1;
            bit_cnt_nxt = bit_cnt_r + 7'd1;
          end else begin
            sclk_nxt = 1'b0;
            // The falling edge after the last rise closes the frame.
            if (bit_cnt_r == nbits_r) begin
              state_nxt = ST_CS_HOLD;
            end else begin
              shreg_nxt = shreg_r << 1;
              sdio_nxt  = shreg_r[SHIFT_W-2];
            end
          end
        end
      end
      ST_CS_HOLD: begin
        if (tick) begin
          cs_n_nxt    = 1'b1;
          upd_cnt_nxt = '0;
          state_nxt   = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        // Runs on reference clocks, not ticks.
        if (upd_cnt_r < UPD_LEN) begin
          io_upd_nxt  = 1'b1;
          upd_cnt_nxt = upd_cnt_r + 4'd1;
        end else begin
          io_upd_nxt = 1'b0;
          done_nxt   = 1'b1;
          busy_nxt   = 1'b0;
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge FiftyMHz_ref_clock or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      cs_n_r    <= 1'b1;
      sclk_r    <= 1'b0;
      sdio_r    <= 1'b0;
      io_upd_r  <= 1'b0;
      bit_cnt_r <= '0;
      upd_cnt_r <= '0;
    end else begin
      state_r   <= state_nxt;
      busy_r    <= busy_nxt;
      done_r    <= done_nxt;
      cs_n_r    <= cs_n_nxt;
      sclk_r    <= sclk_nxt;
      sdio_r    <= sdio_nxt;
      io_upd_r  <= io_upd_nxt;
      bit_cnt_r <= bit_cnt_nxt;
      upd_cnt_r <= upd_cnt_nxt;
    end
  end

  // Frame payload registers carry no reset; they are always reloaded on
  // acceptance before being used.
  always_ff @(posedge FiftyMHz_ref_clock) begin
    shreg_r <= shreg_nxt;
    nbits_r <= nbits_nxt;
  end

  assign busy          = busy_r;
  assign done          = done_r;
  assign dds_cs_n      = cs_n_r;
  assign dds_sclk      = sclk_r;
  assign dds_sdio      = sdio_r;
  assign dds_io_update = io_upd_r;

endmodule

// File: tb/tb_dds_serial_writer.sv
module tb_dds_serial_writer;

  localparam int MAXB = 8;
  localparam int UPD  = 4;

  logic        clk;
  logic        rst;
  logic        ten;
  logic        start;
  logic [7:0]  instr;
  logic [63:0] data;
  logic [3:0]  num_bytes;
  logic        busy, done, dds_cs_n, dds_sclk, dds_sdio, dds_io_update;

  logic        div_en;
  int          errors, checks;

  // monitor accumulators (written only by the monitor process)
  int          cyc, rises, bad_rises, io_cycles, done_cnt, cs_low_ticks;
  int          cs_rise_cyc, done_cyc, cs_high_run, last_gap;
  logic [71:0] obs_bits;

  dds_serial_writer #(.MAX_BYTES(MAXB), .IO_UPDATE_CYCLES(UPD)) dut (
    .FiftyMHz_ref_clock (clk),
    .reset              (rst),
    .TenMHz_receiver    (ten),
    .start              (start),
    .instr              (instr),
    .data               (data),
    .num_bytes          (num_bytes),
    .busy               (busy),
    .done               (done),
    .dds_cs_n           (dds_cs_n),
    .dds_sclk           (dds_sclk),
    .dds_sdio           (dds_sdio),
    .dds_io_update      (dds_io_update)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // 5-clock divider: high 2 clocks, low 3 clocks
  initial begin
    int dcnt;
    dcnt = 0;
    ten  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (div_en) begin
        dcnt = (dcnt == 4) ? 0 : dcnt + 1;
        ten  = (dcnt < 2);
      end else begin
        ten = 1'b0;
      end
    end
  end

  // Observer sampling on the falling edge
  initial begin
    logic lvl_prev, sclk_prev, cs_prev;
    cyc = 0; rises = 0; bad_rises = 0; io_cycles = 0; done_cnt = 0;
    cs_low_ticks = 0; cs_rise_cyc = 0; done_cyc = 0; cs_high_run = 0;
    last_gap = 0; obs_bits = '0;
    lvl_prev = 1'b1; sclk_prev = 1'b0; cs_prev = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      // a fresh divider rise here is consumed at the next rising clock
      if (ten && !lvl_prev && !dds_cs_n) cs_low_ticks++;
      lvl_prev = ten;
      if (dds_sclk && !sclk_prev) begin
        rises++;
        obs_bits = {obs_bits[70:0], dds_sdio};
        if (dds_cs_n) bad_rises++;
      end
      sclk_prev = dds_sclk;
      if (dds_io_update) io_cycles++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (dds_cs_n && !cs_prev) cs_rise_cyc = cyc;
      if (dds_cs_n) cs_high_run++;
      else begin
        if (cs_prev) last_gap = cs_high_run;
        cs_high_run = 0;
      end
      cs_prev = dds_cs_n;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp_nb(input logic [3:0] nb);
    return (int'(nb) > MAXB) ? MAXB : int'(nb);
  endfunction

  // Expected serial frame: instruction, then used bytes from highest to lowest.
  function automatic logic [71:0] exp_stream(input logic [7:0] ins, input logic [63:0] d,
                                             input int nbc);
    logic [71:0] r;
    r = 72'(ins);
    for (int b = nbc - 1; b >= 0; b--) r = (r << 8) | 72'(d[8*b +: 8]);
    return r;
  endfunction

  function automatic logic [71:0] low_bits(input logic [71:0] v, input int n);
    logic [71:0] m;
    m = (n >= 72) ? '1 : ((72'd1 << n) - 72'd1);
    return v & m;
  endfunction

  task automatic wait_done(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_transfer(input string tag, input logic [7:0] ins, input logic [63:0] d,
                             input logic [3:0] nb, input bit poke);
    int r0, io0, d0, ct0, bad0, n;
    bit seen;
    n = 8 * (1 + clamp_nb(nb));
    @(posedge clk); #1;
    r0 = rises; io0 = io_cycles; d0 = done_cnt; ct0 = cs_low_ticks; bad0 = bad_rises;
    instr = ins; data = d; num_bytes = nb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    instr = 8'($urandom); data = {$urandom, $urandom}; num_bytes = 4'($urandom);
    check({tag, "_busy_rise"}, 72'(busy), 72'd1);
    if (poke) begin
      repeat (100) @(posedge clk);
      #1;
      instr = ~ins; num_bytes = 4'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_done(3000, seen);
    check({tag, "_done_seen"}, 72'(seen), 72'd1);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_rises"}, 72'(rises - r0), 72'(n));
    check({tag, "_bits"}, low_bits(obs_bits, n), exp_stream(ins, d, clamp_nb(nb)));
    check({tag, "_rise_cs_high"}, 72'(bad_rises - bad0), 72'd0);
    check({tag, "_io_update_len"}, 72'(io_cycles - io0), 72'(UPD));
    check({tag, "_cs_span_ticks"}, 72'(cs_low_ticks - ct0 - 1), 72'(2 * n + 1));
    check({tag, "_cs_to_done"}, 72'(done_cyc - cs_rise_cyc), 72'(UPD + 1));
    repeat (20) @(posedge clk);
    #1;
    check({tag, "_done_once"}, 72'(done_cnt - d0), 72'd1);
    check({tag, "_idle_after"}, {70'd0, busy, dds_cs_n}, 72'b01);
  endtask

  initial begin
    int r0, io0, d0, n1, n2;
    bit seen;
    logic [63:0] d1, d2;
    logic [3:0] nb1, nb2;
    errors = 0; checks = 0;
    rst = 1'b1; div_en = 1'b0; start = 1'b0;
    instr = '0; data = '0; num_bytes = '0;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 72'(busy), 72'd0);
    check("rst_done", 72'(done), 72'd0);
    check("rst_cs_n", 72'(dds_cs_n), 72'd1);
    check("rst_sclk", 72'(dds_sclk), 72'd0);
    check("rst_sdio", 72'(dds_sdio), 72'd0);
    check("rst_io_update", 72'(dds_io_update), 72'd0);
    rst = 1'b0;

    // 20 ticks with no start
    div_en = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("idle_rises", 72'(rises), 72'd0);
    check("idle_outputs", {66'd0, busy, done, dds_cs_n, dds_sclk, dds_sdio, dds_io_update},
          72'b001000);
    check("idle_io_cycles", 72'(io_cycles), 72'd0);

    do_transfer("t8a", 8'h8A, {$urandom, $urandom}, 4'd0, 1'b0);
    do_transfer("tdead", 8'h01, {$urandom, 32'hDEADBEEF}, 4'd4, 1'b0);
    do_transfer("tclamp", 8'($urandom), {$urandom, $urandom}, 4'd12, 1'b1);

    // back-to-back: start issued in the done cycle
    d1 = {$urandom, $urandom}; nb1 = 4'($urandom_range(0, 8)); n1 = 8 * (1 + clamp_nb(nb1));
    d2 = {$urandom, $urandom}; nb2 = 4'($urandom_range(0, 8)); n2 = 8 * (1 + clamp_nb(nb2));
    @(posedge clk); #1;
    r0 = rises; d0 = done_cnt;
    instr = 8'h5C; data = d1; num_bytes = nb1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(3000, seen);
    check("b2b_first_done", 72'(seen), 72'd1);
    instr = 8'h02; data = d2; num_bytes = nb2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_second_accepted", {70'd0, busy, dds_cs_n}, 72'b10);
    check("b2b_first_rises", 72'(rises - r0), 72'(n1));
    check("b2b_first_bits", low_bits(obs_bits, n1), exp_stream(8'h5C, d1, clamp_nb(nb1)));
    r0 = rises;
    wait_done(3000, seen);
    check("b2b_second_done", 72'(seen), 72'd1);
    repeat (3) @(posedge clk);
    #1;
    check("b2b_second_rises", 72'(rises - r0), 72'(n2));
    check("b2b_second_bits", low_bits(obs_bits, n2), exp_stream(8'h02, d2, clamp_nb(nb2)));
    check("b2b_cs_gap", 72'(last_gap >= 5), 72'd1);
    check("b2b_done_count", 72'(done_cnt - d0), 72'd2);

    // reset at SCLK rise 13 of a 40-bit transfer
    @(posedge clk); #1;
    r0 = rises; io0 = io_cycles; d0 = done_cnt;
    instr = 8'($urandom); data = {$urandom, $urandom}; num_bytes = 4'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3000 && (rises - r0) < 13; i++) @(posedge clk);
    #2;
    check("abort_at_rise13", 72'(rises - r0), 72'd13);
    rst = 1'b1;
    #1;
    check("abort_cs_n", 72'(dds_cs_n), 72'd1);
    check("abort_sclk", 72'(dds_sclk), 72'd0);
    check("abort_busy", 72'(busy), 72'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    check("abort_no_io_update", 72'(io_cycles - io0), 72'd0);
    check("abort_no_done", 72'(done_cnt - d0), 72'd0);
    check("abort_no_more_rises", 72'(rises - r0), 72'd13);
    do_transfer("post_abort", 8'($urandom), {$urandom, $urandom}, 4'($urandom_range(0, 8)), 1'b0);

    // randomized transfers, including out-of-range byte counts
    for (int k = 0; k < 3; k++)
      do_transfer($sformatf("rnd%0d", k), 8'($urandom), {$urandom, $urandom},
                  4'($urandom_range(0, 15)), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
